counter_sequencer: RTL and testbench
====================================

Name: counter_sequencer

Overview:
- Run controller for the Size-bit up-counter datapath: sequences it through start, pause, stop and terminal-count events against a programmable limit.
- Supports one-shot and periodic (auto-reload) modes, with a busy/done handshake toward a host or Ruby-VPI bench.
- Sits between control logic and the counter. It owns the count register, so it can drop in wherever the bare counter is used today.

Parameters:
Size, 5, width of count and limit
WrapWidth, 4, width of the saturating completed-period counter

Ports:
clock  in  1  system clock; all state updates on posedge
reset  in  1  asynchronous, active-low reset; clears all state while 0
start  in  1  request a run; sampled only in IDLE
stop   in  1  abort current run; highest priority
pause  in  1  level; freezes count while 1 during a run
periodic  in  1  1 = auto-reload at limit; sampled with start
limit  in  Size  terminal count value; sampled with start
count  out  Size  current count
busy  out  1  1 while in RUN or HOLD
done  out  1  one-cycle pulse on each terminal count
wraps  out  WrapWidth  completed periods in current run, saturating

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; count=0, busy=0, done=0, wraps=0.
  - limit_q=0, periodic_q=0.
  - Takes effect immediately, including mid-run. No done pulse is generated on reset.
- All outputs are registered. done defaults to 0 every cycle unless set by a terminal event.
- States: IDLE, RUN, HOLD.
- Per-edge priority in RUN/HOLD: stop > pause > terminal > increment.
- IDLE:
  - start=1, stop=0, limit!=0: latch limit_q and periodic_q; count<=0, wraps<=0, busy<=1; go to RUN.
  - start with limit=0: ignored, stay IDLE.
  - start and stop together: stop wins, start ignored.
  - pause is ignored. count holds its last value.
- RUN:
  - stop=1: go to IDLE, busy<=0, count holds, no done.
  - else pause=1: go to HOLD, count holds.
  - else count==limit_q (terminal):
    - always: done<=1.
    - periodic_q=1: count<=0, wraps<=wraps+1 (saturates at all-ones), stay RUN.
    - periodic_q=0: count holds at limit_q, busy<=0, go to IDLE.
  - else: count<=count+1.
- HOLD:
  - stop=1: go to IDLE, busy<=0.
  - else pause=0: return to RUN. No count change on the resume edge; counting resumes on the following edge.
  - A terminal match pending while paused is evaluated in RUN after resume.
- Latency:
  - Start sampled at edge E0 gives count=0 and busy=1 after E0.
  - count=k after E0+k.
  - Terminal edge is E0+limit+1; done is high for the cycle following it.
  - A one-shot run occupies limit+1 busy cycles.
- Changes to limit or periodic during a run have no effect; only the latched copies are used.
- start while busy is ignored; no queuing.
- No overflow is possible since count never exceeds limit_q ≤ 2^Size−1.

Test Plan:
1. Reset=0 mid-run at count=3, then release → all outputs 0 immediately, state IDLE; later start works normally.
2. One-shot, limit=3, start pulse at E0 → count 0,1,2,3 after E0..E3; after E4 done=1, busy=0, count=3; after E5 done=0.
3. Periodic, limit=2, run 3 periods → done pulses every 3 cycles, count sequence 0,1,2,0,1,2…, wraps=3. With WrapWidth=2 and 5 periods → wraps saturates at 3.
4. Limit=4, pause high for 3 cycles when count=2 → count stays 2 for those cycles plus the resume edge; done arrives 4 cycles later than in an unpaused run.
5. stop asserted at count=1 together with pause → IDLE, busy=0, count=1, no done. start+stop in IDLE → stays IDLE.
6. start with limit=0 → no busy, no done. start while busy with limit=7 → ignored, original limit honoured.

Source files
------------

// File: rtl/counter_sequencer.sv
// rtl/counter_sequencer.sv - run controller owning the count register: start/pause/stop, one-shot or auto-reload against a latched limit
module counter_sequencer #(
    parameter int Size      = 5,
    parameter int WrapWidth = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 pause,
    input  logic                 periodic,
    input  logic [Size-1:0]      limit,
    output logic [Size-1:0]      count,
    output logic                 busy,
    output logic                 done,
    output logic [WrapWidth-1:0] wraps
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [Size-1:0]      r_count, w_count_nxt;
    logic [Size-1:0]      r_limit, w_limit_nxt;
    logic                 r_periodic, w_periodic_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_done, w_done_nxt;
    logic [WrapWidth-1:0] r_wraps, w_wraps_nxt;
    logic                 w_terminal;

    assign w_terminal = (r_count == r_limit);

    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_limit_nxt    = r_limit;
        w_periodic_nxt = r_periodic;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_wraps_nxt    = r_wraps;
        case (r_state)
            ST_IDLE: begin
                if (start && !stop && (limit != '0)) begin
                    w_limit_nxt    = limit;
                    w_periodic_nxt = periodic;
                    w_count_nxt    = '0;
                    w_wraps_nxt    = '0;
                    w_busy_nxt     = 1'b1;
                    w_state_nxt    = ST_RUN;
                end
            end
            ST_RUN: begin
                // stop > pause > terminal > increment
                if (stop) begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else if (pause) begin
                    w_state_nxt = ST_HOLD;
                end else if (w_terminal) begin
                    w_done_nxt = 1'b1;
                    if (r_periodic) begin
                        w_count_nxt = '0;
                        if (r_wraps != '1) w_wraps_nxt = r_wraps + 1'b1;
                    end else begin
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_count_nxt = r_count + 1'b1;
                end
            end
            ST_HOLD: begin
                // Resume edge only changes state; counting restarts on the next edge.
                if (stop) begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else if (!pause) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_limit    <= '0;
            r_periodic <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_wraps    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_limit    <= w_limit_nxt;
            r_periodic <= w_periodic_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_wraps    <= w_wraps_nxt;
        end
    end

    assign count = r_count;
    assign busy  = r_busy;
    assign done  = r_done;
    assign wraps = r_wraps;

endmodule

// File: tb/tb_counter_sequencer.sv
// tb/tb_counter_sequencer.sv - vector table, corner sequences and randomized run against a reference model
module tb_counter_sequencer;

    localparam int Size      = 5;
    localparam int WrapWidth = 4;
    localparam int WrapMax   = (1 << WrapWidth) - 1;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic                 start = 1'b0;
    logic                 stop = 1'b0;
    logic                 pause = 1'b0;
    logic                 periodic = 1'b0;
    logic [Size-1:0]      limit = '0;
    logic [Size-1:0]      count;
    logic                 busy;
    logic                 done;
    logic [WrapWidth-1:0] wraps;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    bit m_active, m_paused, m_per, m_done;
    int m_count, m_wraps, m_lim;

    typedef struct {
        int s, st, p, per, lim;
        int e_count, e_busy, e_done, e_wraps;
    } vec_t;

    vec_t vecs[18];

    counter_sequencer #(.Size(Size), .WrapWidth(WrapWidth)) dut (
        .clock(clock), .reset(reset), .start(start), .stop(stop), .pause(pause),
        .periodic(periodic), .limit(limit), .count(count), .busy(busy),
        .done(done), .wraps(wraps)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_paused = 0; m_per = 0; m_done = 0;
        m_count = 0; m_wraps = 0; m_lim = 0;
    endtask

    task automatic model_edge(input bit s, input bit st, input bit p, input bit per, input int lim);
        m_done = 0;
        if (!m_active) begin
            if (s && !st && lim != 0) begin
                m_active = 1; m_paused = 0; m_lim = lim; m_per = per;
                m_count = 0; m_wraps = 0;
            end
        end else if (st) begin
            m_active = 0;
        end else if (m_paused) begin
            m_paused = p;
        end else if (p) begin
            m_paused = 1;
        end else if (m_count == m_lim) begin
            m_done = 1;
            if (m_per) begin
                m_count = 0;
                m_wraps = (m_wraps + 1 > WrapMax) ? WrapMax : m_wraps + 1;
            end else begin
                m_active = 0;
            end
        end else begin
            m_count = m_count + 1;
        end
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic apply(input bit s, input bit st, input bit p, input bit per, input int lim);
        start = s; stop = st; pause = p; periodic = per; limit = lim[Size-1:0];
        @(posedge clock);
        model_edge(s, st, p, per, lim);
        @(negedge clock);
    endtask

    task automatic idle_step();
        apply(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        reset = 0;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        reset = 1;
    endtask

    initial begin
        vecs[0]  = '{1, 0, 0, 0, 3,   0, 1, 0, 0};
        vecs[1]  = '{0, 0, 0, 0, 0,   1, 1, 0, 0};
        vecs[2]  = '{0, 0, 0, 0, 0,   2, 1, 0, 0};
        vecs[3]  = '{0, 0, 0, 0, 0,   3, 1, 0, 0};
        vecs[4]  = '{0, 0, 0, 0, 0,   3, 0, 1, 0};
        vecs[5]  = '{0, 0, 0, 0, 0,   3, 0, 0, 0};
        vecs[6]  = '{1, 0, 0, 0, 0,   3, 0, 0, 0};
        vecs[7]  = '{1, 1, 0, 0, 5,   3, 0, 0, 0};
        vecs[8]  = '{1, 0, 0, 1, 2,   0, 1, 0, 0};
        vecs[9]  = '{0, 0, 0, 0, 0,   1, 1, 0, 0};
        vecs[10] = '{0, 0, 0, 0, 0,   2, 1, 0, 0};
        vecs[11] = '{0, 0, 0, 0, 0,   0, 1, 1, 1};
        vecs[12] = '{1, 0, 0, 0, 7,   1, 1, 0, 1};
        vecs[13] = '{0, 0, 0, 0, 0,   2, 1, 0, 1};
        vecs[14] = '{0, 0, 0, 0, 0,   0, 1, 1, 2};
        vecs[15] = '{0, 0, 0, 0, 0,   1, 1, 0, 2};
        vecs[16] = '{0, 1, 1, 0, 0,   1, 0, 0, 2};
        vecs[17] = '{0, 0, 1, 0, 0,   1, 0, 0, 2};

        @(negedge clock);
        do_reset();
        chk("reset_count", int'(count), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_wraps", int'(wraps), 0);

        for (int i = 0; i < 18; i++) begin
            apply(vecs[i].s[0], vecs[i].st[0], vecs[i].p[0], vecs[i].per[0], vecs[i].lim);
            chk($sformatf("vec%0d_count", i), int'(count), vecs[i].e_count);
            chk($sformatf("vec%0d_busy", i), int'(busy), vecs[i].e_busy);
            chk($sformatf("vec%0d_done", i), int'(done), vecs[i].e_done);
            chk($sformatf("vec%0d_wraps", i), int'(wraps), vecs[i].e_wraps);
        end

        // pause for three edges at count=2, limit=4: terminal slips by four edges
        begin
            int pc[10] = '{0, 1, 2, 2, 2, 2, 2, 3, 4, 4};
            for (int s = 0; s < 10; s++) begin
                apply(s == 0, 0, (s >= 3 && s <= 5), 0, 4);
                chk($sformatf("pause_s%0d_count", s), int'(count), pc[s]);
                chk($sformatf("pause_s%0d_busy", s), int'(busy), (s < 9) ? 1 : 0);
                chk($sformatf("pause_s%0d_done", s), int'(done), (s == 9) ? 1 : 0);
            end
        end

        // wraps saturation: limit=1 periodic, one period every 2 edges
        apply(1, 0, 0, 1, 1);
        for (int s = 1; s <= 40; s++) begin
            idle_step();
            if (s == 10) chk("wraps_at_5", int'(wraps), 5);
        end
        chk("wraps_saturated", int'(wraps), WrapMax);
        chk("wraps_sat_count", int'(count), 0);
        apply(0, 1, 0, 0, 0);
        chk("wraps_stop_busy", int'(busy), 0);

        // asynchronous reset mid-run at count=3
        apply(1, 0, 0, 0, 6);
        for (int s = 0; s < 3; s++) idle_step();
        chk("pre_reset_count", int'(count), 3);
        reset = 0;
        #1;
        chk("async_reset_count", int'(count), 0);
        chk("async_reset_busy", int'(busy), 0);
        chk("async_reset_done", int'(done), 0);
        chk("async_reset_wraps", int'(wraps), 0);
        model_reset();
        @(negedge clock);
        reset = 1;
        apply(1, 0, 0, 0, 2);
        chk("post_reset_start_count", int'(count), 0);
        chk("post_reset_start_busy", int'(busy), 1);
        idle_step(); idle_step(); idle_step();
        chk("post_reset_done", int'(done), 1);
        chk("post_reset_count", int'(count), 2);

        // randomized stimulus against the reference model
        do_reset();
        for (int c = 0; c < 600; c++) begin
            bit s, st, p, per;
            int lim;
            s   = ($urandom_range(0, 3) == 0);
            st  = ($urandom_range(0, 15) == 0);
            p   = ($urandom_range(0, 5) == 0);
            per = $urandom_range(0, 1);
            lim = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 6);
            apply(s, st, p, per, lim);
            chk("rand_count", int'(count), m_count);
            chk("rand_busy", int'(busy), int'(m_active));
            chk("rand_done", int'(done), int'(m_done));
            chk("rand_wraps", int'(wraps), m_wraps);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
